block_mem_ctrl: RTL and testbench

Block-transfer memory controller sitting directly downstream of the data cache. Accepts the cache's one-cycle block fill (`bread`) and write-back (`bwrite`) pulses, serialises each 256-bit block into word-wide beats on a request/acknowledge main-memory bus, and returns assembled fill blocks to the cache. An optional one-entry write buffer lets a victim write-back be deferred behind the fill that displaced it.

---
 rtl/block_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_block_mem_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_mem_ctrl.sv
`default_nettype none
// ============================================================================
// block_mem_ctrl : serialises 256-bit cache fills / write-backs into word beats
// on a req/ack memory bus. Define BMC_WRITE_BUFFER_EN for the victim buffer.
// Revision 1.0
// ============================================================================
module block_mem_ctrl #(
  parameter int DATA = 32,
  parameter int ADDR = 32,
  parameter int OFST = 5,
  parameter int BLCK = 8 << OFST
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            bread,
  input  logic            bwrite,
  input  logic [ADDR-1:0] rd_address,
  input  logic [ADDR-1:0] wr_address,
  input  logic [BLCK-1:0] block_wr,
  output logic [BLCK-1:0] block_rd,
  output logic            fill_valid,
  output logic            busy,
  output logic            overrun,
  output logic            mem_req,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_wdata,
  input  logic [DATA-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam int NB  = BLCK / DATA;
  localparam int BW  = $clog2(NB);
  localparam int TAG = ADDR - OFST;
  localparam int PAD = OFST - BW;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    FWD   = 2'd3
  } state_t;

  state_t          state;
  logic [BW-1:0]   beat;
  logic [BW-1:0]   beat_inc;
  logic            wb_valid;
  logic [TAG-1:0]  wb_tag;
  logic [BLCK-1:0] wb_block;
  logic [TAG-1:0]  rd_tag;
  logic            rd_pend;
  logic [BLCK-1:0] asm_blk;
  logic [BLCK-1:0] fill_blk;
  logic [TAG-1:0]  rd_tag_in;
  logic [TAG-1:0]  wr_tag_in;
  logic            unused_bits;

  assign rd_tag_in   = rd_address[ADDR-1:OFST];
  assign wr_tag_in   = wr_address[ADDR-1:OFST];
  assign unused_bits = ^{rd_address[OFST-1:0], wr_address[OFST-1:0]};
  assign beat_inc    = beat + 1'b1;
  assign busy        = (state != IDLE) | wb_valid;

`ifdef BMC_WRITE_BUFFER_EN
  logic hit_buf;
  logic hit_new;
  // A fill of the block sitting in (or just entering) the buffer must see the victim data
  assign hit_buf = wb_valid && (rd_tag_in == wb_tag);
  assign hit_new = bwrite && !wb_valid && (rd_tag_in == wr_tag_in);
`endif

  function automatic logic [ADDR-1:0] beat_addr(input logic [TAG-1:0] tag, input logic [BW-1:0] k);
    return {tag, k, {PAD{1'b0}}};
  endfunction

  function automatic logic [DATA-1:0] word_of(input logic [BLCK-1:0] b, input int k);
    return b[k*DATA +: DATA];
  endfunction

  // Final word is taken straight from the bus so block_rd is ready the cycle after the last ack
  always_comb begin
    fill_blk = asm_blk;
    fill_blk[BLCK-1 -: DATA] = mem_rdata;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      beat       <= '0;
      block_rd   <= '0;
      fill_valid <= 1'b0;
      overrun    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wb_valid   <= 1'b0;
      wb_tag     <= '0;
      wb_block   <= '0;
      rd_tag     <= '0;
      rd_pend    <= 1'b0;
      asm_blk    <= '0;
    end else begin
      fill_valid <= 1'b0;

      if (state != IDLE) begin
        if (bread) overrun <= 1'b1;
`ifdef BMC_WRITE_BUFFER_EN
        if (bwrite) begin
          if (state == READ && !wb_valid) begin
            wb_valid <= 1'b1;
            wb_tag   <= wr_tag_in;
            wb_block <= block_wr;
          end else begin
            overrun <= 1'b1;
          end
        end
`else
        if (bwrite) overrun <= 1'b1;
`endif
      end

      case (state)
        IDLE: begin
`ifdef BMC_WRITE_BUFFER_EN
          if (bwrite) begin
            if (wb_valid) begin
              overrun <= 1'b1;
            end else begin
              wb_valid <= 1'b1;
              wb_tag   <= wr_tag_in;
              wb_block <= block_wr;
            end
          end
          if (bread) begin
            if (hit_buf || hit_new) begin
              state <= FWD;
            end else begin
              state     <= READ;
              rd_tag    <= rd_tag_in;
              beat      <= '0;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= beat_addr(rd_tag_in, '0);
              mem_wdata <= '0;
            end
          end else if (wb_valid) begin
            state     <= WRITE;
            beat      <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= beat_addr(wb_tag, '0);
            mem_wdata <= wb_block[DATA-1:0];
          end
`else
          if (bwrite) begin
            wb_valid  <= 1'b1;
            wb_tag    <= wr_tag_in;
            wb_block  <= block_wr;
            rd_pend   <= bread;
            rd_tag    <= rd_tag_in;
            state     <= WRITE;
            beat      <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= beat_addr(wr_tag_in, '0);
            mem_wdata <= block_wr[DATA-1:0];
          end else if (bread) begin
            rd_tag    <= rd_tag_in;
            state     <= READ;
            beat      <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= beat_addr(rd_tag_in, '0);
            mem_wdata <= '0;
          end
`endif
        end

        WRITE: begin
          if (mem_ack) begin
            if (beat == LAST) begin
              beat     <= '0;
              wb_valid <= 1'b0;
              if (rd_pend) begin
                rd_pend   <= 1'b0;
                state     <= READ;
                mem_we    <= 1'b0;
                mem_addr  <= beat_addr(rd_tag, '0);
                mem_wdata <= '0;
              end else begin
                state   <= IDLE;
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
              end
            end else begin
              beat      <= beat_inc;
              mem_addr  <= beat_addr(wb_tag, beat_inc);
              mem_wdata <= word_of(wb_block, int'(beat_inc));
            end
          end
        end

        READ: begin
          if (mem_ack) begin
            asm_blk[int'(beat)*DATA +: DATA] <= mem_rdata;
            if (beat == LAST) begin
              beat       <= '0;
              block_rd   <= fill_blk;
              fill_valid <= 1'b1;
              if (wb_valid) begin
                state     <= WRITE;
                mem_we    <= 1'b1;
                mem_addr  <= beat_addr(wb_tag, '0);
                mem_wdata <= wb_block[DATA-1:0];
              end else begin
                state   <= IDLE;
                mem_req <= 1'b0;
              end
            end else begin
              beat     <= beat_inc;
              mem_addr <= beat_addr(rd_tag, beat_inc);
            end
          end
        end

        FWD: begin
          block_rd   <= wb_block;
          fill_valid <= 1'b1;
          state      <= WRITE;
          beat       <= '0;
          mem_req    <= 1'b1;
          mem_we     <= 1'b1;
          mem_addr   <= beat_addr(wb_tag, '0);
          mem_wdata  <= wb_block[DATA-1:0];
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_mem_ctrl.sv
`default_nettype none
// tb_block_mem_ctrl : directed stimulus with a bus/fill scoreboard for block_mem_ctrl.
module tb_block_mem_ctrl;
  localparam int NB = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         bread, bwrite;
  logic [31:0]  rd_address, wr_address;
  logic [255:0] block_wr, block_rd;
  logic         fill_valid, busy, overrun;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic [31:0]  mem_rdata = 32'd0;
  logic         mem_ack = 1'b0;

  block_mem_ctrl dut (
    .CLK(CLK), .RESET(RESET), .bread(bread), .bwrite(bwrite),
    .rd_address(rd_address), .wr_address(wr_address), .block_wr(block_wr),
    .block_rd(block_rd), .fill_valid(fill_valid), .busy(busy), .overrun(overrun),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          cyc;
  } beat_t;
  typedef struct {
    logic [255:0] blk;
    int           cyc;
  } fill_t;

  beat_t beat_q[$];
  fill_t fill_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic  alt_mode = 1'b0;
  int    alt_base = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory: word at 0x1000+4k reads k+0xA0; other 4K pages get a distinct top byte
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'hA0 + {29'd0, a[4:2]} + {a[15:12] - 4'd1, 28'd0};
  endfunction

  always @(posedge CLK) begin
    #1;
    mem_rdata = mem_fn(mem_addr);
    mem_ack   = mem_req && (!alt_mode || ((cyc - alt_base) % 2 == 0));
  end

  // Monitor: bus beats, held-request stability and fill completions
  logic        h_stall = 1'b0;
  logic        h_we;
  logic [31:0] h_addr, h_wdata;
  always @(negedge CLK) begin
    beat_t eb;
    fill_t ef;
    if (h_stall) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
        errors++;
        $display("FAIL hold cyc=%0d actual req=%b addr=%h we=%b wdata=%h required req=1 addr=%h we=%b wdata=%h",
                 cyc, mem_req, mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wdata);
      end
    end
    h_stall = (mem_req === 1'b1) && (mem_ack !== 1'b1);
    h_addr  = mem_addr;
    h_we    = mem_we;
    h_wdata = mem_wdata;

    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      checks++;
      if (beat_q.size() == 0) begin
        errors++;
        $display("FAIL beat cyc=%0d actual we=%b addr=%h required no beat", cyc, mem_we, mem_addr);
      end else begin
        eb = beat_q.pop_front();
        if (mem_we !== eb.we || mem_addr !== eb.addr || (eb.chk_wdata && mem_wdata !== eb.wdata) || cyc != eb.cyc) begin
          errors++;
          $display("FAIL beat actual cyc=%0d we=%b addr=%h wdata=%h required cyc=%0d we=%b addr=%h wdata=%h",
                   cyc, mem_we, mem_addr, mem_wdata, eb.cyc, eb.we, eb.addr, eb.wdata);
        end
      end
    end

    if (fill_valid !== 1'b0) begin
      checks++;
      if (fill_q.size() == 0) begin
        errors++;
        $display("FAIL fill cyc=%0d actual fill_valid=%b required no fill", cyc, fill_valid);
      end else begin
        ef = fill_q.pop_front();
        if (block_rd !== ef.blk || cyc != ef.cyc) begin
          errors++;
          $display("FAIL fill actual cyc=%0d blk=%h required cyc=%0d blk=%h", cyc, block_rd, ef.cyc, ef.blk);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((beat_q.size() != 0 || fill_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (beat_q.size() != 0 || fill_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual pending beats=%0d fills=%0d required 0", beat_q.size(), fill_q.size());
      beat_q.delete();
      fill_q.delete();
    end
  endtask

  task automatic exp_read(input logic [31:0] base, input int c0);
    logic [255:0] b;
    for (int k = 0; k < NB; k++) begin
      beat_q.push_back('{1'b0, base + 32'(4*k), 32'd0, 1'b0, c0 + k});
      b[k*32 +: 32] = mem_fn(base + 32'(4*k));
    end
    fill_q.push_back('{b, c0 + NB});
  endtask

  task automatic exp_write(input logic [31:0] base, input logic [255:0] blk, input int c0, input int step);
    for (int k = 0; k < NB; k++)
      beat_q.push_back('{1'b1, base + 32'(4*k), blk[k*32 +: 32], 1'b1, c0 + step*k});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [255:0] blk;
    RESET = 1'b1; bread = 1'b0; bwrite = 1'b0;
    rd_address = '0; wr_address = '0; block_wr = '0;
    repeat (3) tick();
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    chk("rst fill_valid", fill_valid, 0);
    chk("rst block_rd", block_rd, 0);
    RESET = 1'b0;
    tick();

    // Fill of 0x1000 with ack tied high
    c = cyc;
    exp_read(32'h1000, c + 1);
    rd_address = 32'h1000; bread = 1'b1; tick(); bread = 1'b0;
    drain(40);
    chk("t1 word0", block_rd[31:0], 32'hA0);
    chk("t1 word7", block_rd[255:224], 32'hA7);
    chk("t1 busy", busy, 0);

    // Write-back of 0x2000 with ack low every other cycle
    for (int k = 0; k < NB; k++) blk[k*32 +: 32] = 32'(k);
    c = cyc;
    alt_mode = 1'b1; alt_base = c;
    exp_write(32'h2000, blk, c + 2, 2);
    wr_address = 32'h2000; block_wr = blk; bwrite = 1'b1; tick(); bwrite = 0;
    drain(60);
    chk("t2 busy", busy, 0);
    alt_mode = 1'b0;
    tick();

    // Simultaneous fill 0x3000 and write-back 0x4000
    for (int k = 0; k < NB; k++) blk[k*32 +: 32] = 32'hC0DE0000 + 32'(k);
    c = cyc;
`ifdef BMC_WRITE_BUFFER_EN
    exp_read(32'h3000, c + 1);
    exp_write(32'h4000, blk, c + 9, 1);
`else
    exp_write(32'h4000, blk, c + 1, 1);
    exp_read(32'h3000, c + 9);
`endif
    rd_address = 32'h3000; wr_address = 32'h4000; block_wr = blk;
    bread = 1'b1; bwrite = 1'b1; tick(); bread = 1'b0; bwrite = 1'b0;
    drain(60);
    chk("t3 busy", busy, 0);
    chk("t3 overrun", overrun, 0);

`ifdef BMC_WRITE_BUFFER_EN
    // Fill hits the buffered victim: forwarded, then the victim drains
    for (int k = 0; k < NB; k++) blk[k*32 +: 32] = 32'hDEAD0000 + 32'(k);
    c = cyc;
    fill_q.push_back('{blk, c + 3});
    exp_write(32'h5000, blk, c + 3, 1);
    wr_address = 32'h5000; block_wr = blk; bwrite = 1'b1; tick(); bwrite = 1'b0;
    rd_address = 32'h5000; bread = 1'b1; tick(); bread = 1'b0;
    drain(40);
    chk("fwd busy", busy, 0);
`endif

    // Reset during beat 4 of a fill aborts it
    c = cyc;
    for (int k = 0; k < 5; k++) beat_q.push_back('{1'b0, 32'h1000 + 32'(4*k), 32'd0, 1'b0, c + 1 + k});
    rd_address = 32'h1000; bread = 1'b1; tick(); bread = 1'b0;
    repeat (4) tick();
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("t4 mem_req", mem_req, 0);
    chk("t4 busy", busy, 0);
    chk("t4 overrun", overrun, 0);
    repeat (12) tick();
    drain(5);
    chk("t4 fill_valid", fill_valid, 0);

    // Second fill during READ is dropped and overrun sticks until reset
    c = cyc;
    exp_read(32'h1000, c + 1);
    rd_address = 32'h101C; bread = 1'b1; tick(); bread = 1'b0;
    tick(); tick();
    rd_address = 32'h3000; bread = 1'b1; tick(); bread = 1'b0;
    chk("t5 overrun set", overrun, 1);
    drain(40);
    repeat (3) tick();
    chk("t5 overrun sticky", overrun, 1);
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("t5 overrun clear", overrun, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
